// File: rtl/btn_cond_pkg.sv
// Shared definitions for the button conditioner.
// Register offsets within the peripheral window and the button count limit.
package btn_cond_pkg;

   localparam int N_BTN_MAX = 8;

   localparam logic [7:0] OFF_LEVEL  = 8'h00;
   localparam logic [7:0] OFF_RISE   = 8'h04;
   localparam logic [7:0] OFF_FALL   = 8'h08;
   localparam logic [7:0] OFF_THRESH = 8'h0C;
   localparam logic [7:0] OFF_PRESS  = 8'h10;

endpackage

// File: rtl/button_conditioner_debounce.sv
// One debounce lane: two-flop synchroniser, stability counter and clean level.
// rise/fall pulse combinationally in the cycle whose edge commits a new level.
module debounce_channel #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             raw,
   input  logic [CNT_W-1:0] eff,
   output logic             clean,
   output logic             rise,
   output logic             fall
);

   logic             s1_q;
   logic             s2_q;
   logic             clean_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W:0]   cnt_inc;
   logic             commit;

   assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign commit  = (s2_q != clean_q) && (cnt_inc >= {1'b0, eff});
   assign clean   = clean_q;
   assign rise    = commit && s2_q;
   assign fall    = commit && !s2_q;

   // Synchronise, then count consecutive cycles the input differs from the clean level.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         clean_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         s1_q <= raw;
         s2_q <= s1_q;
         if (s2_q == clean_q) begin
            cnt_q <= '0;
         end else if (commit) begin
            clean_q <= s2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_inc[CNT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner: per-button debounce lanes plus a firmware register slave
// exposing levels, sticky edge flags, press counters and the debounce threshold.
module button_conditioner
   import btn_cond_pkg::*;
#(
   parameter int N_BTN       = 3,
   parameter int CNT_W       = 20,
   parameter int DEB_DEFAULT = 120000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_clean,
   input  logic [15:0]      addr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wstrb,
   input  logic             valid,
   output logic             ready,
   output logic [31:0]      rdata
);

   localparam int PW = (N_BTN < 4) ? N_BTN : 4;

   logic [CNT_W-1:0] thresh_q, thresh_d;
   logic [CNT_W-1:0] eff;
   logic [N_BTN-1:0] rise_p, fall_p;
   logic [N_BTN-1:0] rise_q, rise_d;
   logic [N_BTN-1:0] fall_q, fall_d;
   logic [7:0]       press_q [N_BTN];
   logic [7:0]       press_d [N_BTN];
   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             req, wr;
   logic [5:0]       sel;
   logic             wr_rise, wr_fall, wr_th, wr_press;
   logic [31:0]      rd_val;
   logic [31:0]      th_merge;
   logic [31:0]      press_word;
   logic [N_BTN-1:0] w1c;
   logic             unused_ok;

   assign eff   = (thresh_q == '0) ? CNT_W'(1) : thresh_q;
   assign ready = ready_q;
   assign rdata = rdata_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      debounce_channel #(.CNT_W(CNT_W)) u_ch (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[i]),
         .eff   (eff),
         .clean (btn_clean[i]),
         .rise  (rise_p[i]),
         .fall  (fall_p[i])
      );
   end

   // Bus decode, read mux and next state of flags, counters and threshold.
   always_comb begin
      req      = valid && !ready_q;
      wr       = req && (wstrb != 4'b0000);
      sel      = addr[7:2];
      wr_rise  = wr && wstrb[0] && (sel == OFF_RISE[7:2]);
      wr_fall  = wr && wstrb[0] && (sel == OFF_FALL[7:2]);
      wr_th    = wr && (sel == OFF_THRESH[7:2]);
      wr_press = wr && (sel == OFF_PRESS[7:2]);

      press_word = '0;
      for (int i = 0; i < PW; i++) begin
         press_word[8*i +: 8] = press_q[i];
      end

      rd_val = '0;
      case (sel)
         OFF_LEVEL[7:2]:  rd_val = 32'(btn_clean);
         OFF_RISE[7:2]:   rd_val = 32'(rise_q);
         OFF_FALL[7:2]:   rd_val = 32'(fall_q);
         OFF_THRESH[7:2]: rd_val = 32'(thresh_q);
         OFF_PRESS[7:2]:  rd_val = press_word;
         default:         rd_val = '0;
      endcase

      th_merge = 32'(thresh_q);
      for (int b = 0; b < 4; b++) begin
         if (wstrb[b]) th_merge[8*b +: 8] = wdata[8*b +: 8];
      end
      thresh_d = wr_th ? th_merge[CNT_W-1:0] : thresh_q;

      w1c    = wdata[N_BTN-1:0];
      rise_d = (rise_q & ~(wr_rise ? w1c : '0)) | rise_p;
      fall_d = (fall_q & ~(wr_fall ? w1c : '0)) | fall_p;

      for (int i = 0; i < N_BTN; i++) begin
         if (wr_press) press_d[i] = {7'b0, rise_p[i]};
         else          press_d[i] = press_q[i] + {7'b0, rise_p[i]};
      end

      ready_d = req;
      rdata_d = req ? rd_val : '0;
   end

   assign unused_ok = ^{addr[15:8], addr[1:0], th_merge};

   // Register all slave-visible state.
   always_ff @(posedge clk) begin
      if (reset) begin
         thresh_q <= CNT_W'(DEB_DEFAULT);
         rise_q   <= '0;
         fall_q   <= '0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         for (int i = 0; i < N_BTN; i++) press_q[i] <= '0;
      end else begin
         thresh_q <= thresh_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         for (int i = 0; i < N_BTN; i++) press_q[i] <= press_d[i];
      end
   end

endmodule
